// File: rtl/button_pkg.sv
// Shared types and default timing for the button conditioner.
package button_pkg;

  localparam int unsigned CLK_PER_MS_DEF  = 100000;
  localparam int unsigned DEBOUNCE_MS_DEF = 10;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } chan_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM with stable-tick
// counter, registered press pulse and debounced level.
//
// state           | meaning
// ST_RELEASED     | debounced level 0, input low
// ST_PRESS_PEND   | input high, counting stable ms ticks toward a press
// ST_PRESSED      | debounced level 1, held presses never repeat
// ST_RELEASE_PEND | input low, counting stable ms ticks toward a release
module debounce_chan
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
  input  logic clk,
  input  logic clear,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic          sync1_q, sync2_q;
  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          level_q, level_d;

  // Bring the raw button into the clk domain before anything looks at it.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Next state and counter; a sync change always wins over a coincident tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RELEASED: begin
        if (sync2_q) begin
          state_d = ST_PRESS_PEND;
          cnt_d   = '0;
        end
      end
      ST_PRESS_PEND: begin
        if (!sync2_q) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (tick_i) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_PEND;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_PEND: begin
        if (sync2_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (tick_i) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = ST_RELEASED;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Only a fresh acceptance pulses; returning from a rejected release does not.
  always_comb begin
    press_d = (state_q == ST_PRESS_PEND) && (state_d == ST_PRESSED);
    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_PEND);
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      level_q <= level_d;
    end
  end

  assign press_o = press_q;
  assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces N_BTN push buttons against a shared 1 ms tick and emits a
// one-clk press pulse plus a debounced level per channel.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned CLK_PER_MS  = CLK_PER_MS_DEF,
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] level
);

  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  // Free-running ms prescaler shared by every channel.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_chan (
      .clk    (clk),
      .clear  (clear),
      .tick_i (tick),
      .btn_i  (btn_in[i]),
      .press_o(press[i]),
      .level_o(level[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int CPM = 10;
  localparam int DEB = 3;
  localparam int LAT_LO = 22;
  localparam int LAT_HI = 32;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] btn_in;
  logic [1:0] press;
  logic [1:0] level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [1:0] mask;
  } ev_t;

  typedef struct {
    logic [1:0] mask;
    int         lo;
    int         hi;
  } exp_t;

  typedef struct {
    logic [1:0] btn;
    int         hold;
    int         p0;
    int         p1;
    logic [1:0] lvl;
  } vec_t;

  ev_t  obs_q[$];
  exp_t exp_q[$];
  ev_t  mon_ev;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(2),
    .CLK_PER_MS(CPM),
    .DEBOUNCE_MS(DEB)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .btn_in(btn_in),
    .press (press),
    .level (level)
  );

  // monitor: stamp every press event with the edge number it followed
  always @(posedge clk) begin
    #1;
    cyc++;
    if (press != 2'b00) begin
      mon_ev.cyc  = cyc;
      mon_ev.mask = press;
      obs_q.push_back(mon_ev);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // expected press for inputs driven now; first sampling edge is cyc+1
  task automatic expect_press(input logic [1:0] mask);
    exp_t e;
    e.mask = mask;
    e.lo   = cyc + 1 + LAT_LO;
    e.hi   = cyc + 1 + LAT_HI;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    ev_t  o;
    chk({name, " pulse count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o.mask != e.mask || o.cyc < e.lo || o.cyc > e.hi) begin
        bad++;
        $display("FAIL %s pulse: got mask=%b at %0d want mask=%b in %0d..%0d",
                 name, o.mask, o.cyc, e.mask, e.lo, e.hi);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  vec_t vecs[9];

  initial begin
    int   lvl_err;
    int   n0, n1;
    logic [1:0] prev;

    vecs[0] = '{2'b01, 60, 1, 0, 2'b01};
    vecs[1] = '{2'b00, 60, 0, 0, 2'b00};
    vecs[2] = '{2'b10, 60, 0, 1, 2'b10};
    vecs[3] = '{2'b11, 60, 1, 0, 2'b11};
    vecs[4] = '{2'b01,  3, 0, 0, 2'b11};
    vecs[5] = '{2'b11, 60, 0, 0, 2'b11};
    vecs[6] = '{2'b00, 60, 0, 0, 2'b00};
    vecs[7] = '{2'b11, 60, 1, 1, 2'b11};
    vecs[8] = '{2'b00, 60, 0, 0, 2'b00};

    clear  = 1'b1;
    btn_in = 2'b00;
    step(3);
    chk("reset press", int'(press), 0);
    chk("reset level", int'(level), 0);
    clear = 1'b0;
    step(5);
    obs_q.delete();

    // clean press
    btn_in = 2'b01;
    expect_press(2'b01);
    lvl_err = 0;
    prev = 2'b00;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (prev[0] && !level[0]) lvl_err++;
      prev = press;
    end
    chk("clean level after pulse", lvl_err, 0);
    chk("clean level held", int'(level), 1);
    sb_check("clean");
    btn_in = 2'b00;
    step(40);
    chk("clean release level", int'(level), 0);
    sb_check("clean release");

    // bounce
    for (int i = 0; i < 15; i++) begin
      btn_in[0] = ~btn_in[0];
      if (i < 14) step(4);
    end
    chk("bounce no pulse", obs_q.size(), 0);
    obs_q.delete();
    expect_press(2'b01);
    step(54);
    sb_check("bounce");
    btn_in = 2'b00;
    step(40);
    obs_q.delete();

    // release glitch
    btn_in = 2'b01;
    expect_press(2'b01);
    step(50);
    btn_in = 2'b00;
    step(5);
    btn_in = 2'b01;
    lvl_err = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (!level[0]) lvl_err++;
    end
    chk("glitch level held", lvl_err, 0);
    sb_check("glitch");
    btn_in = 2'b00;
    step(40);
    chk("real release level", int'(level), 0);
    sb_check("real release");

    // simultaneous
    btn_in = 2'b11;
    expect_press(2'b11);
    step(50);
    chk("simul level", int'(level), 3);
    sb_check("simul");
    btn_in = 2'b00;
    step(40);
    obs_q.delete();

    // clear mid-debounce with button held
    btn_in = 2'b01;
    step(18);
    chk("pre-clear no pulse", obs_q.size(), 0);
    clear = 1'b1;
    #1;
    lvl_err = 0;
    if (press != 2'b00 || level != 2'b00) lvl_err++;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (press != 2'b00 || level != 2'b00) lvl_err++;
    end
    chk("outputs zero in clear", lvl_err, 0);
    chk("no pulse in clear", obs_q.size(), 0);
    obs_q.delete();
    clear = 1'b0;
    expect_press(2'b01);
    step(50);
    sb_check("after clear");
    btn_in = 2'b00;
    step(40);
    obs_q.delete();

    // table-driven vectors
    for (int v = 0; v < 9; v++) begin
      obs_q.delete();
      btn_in = vecs[v].btn;
      step(vecs[v].hold);
      n0 = 0;
      n1 = 0;
      foreach (obs_q[k]) begin
        if (obs_q[k].mask[0]) n0++;
        if (obs_q[k].mask[1]) n1++;
      end
      chk($sformatf("vec%0d press0", v), n0, vecs[v].p0);
      chk($sformatf("vec%0d press1", v), n1, vecs[v].p1);
      chk($sformatf("vec%0d level", v), int'(level), int'(vecs[v].lvl));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter N_BTN, default 2, the number of independent button channels (bit 0 = start, bit 1 = stop).
REQ-002 The block SHALL have parameter CLK_PER_MS, default 100000, the clk cycles per 1 ms tick (100 MHz clock).
REQ-003 The block SHALL have parameter DEBOUNCE_MS, default 10, the whole ms ticks of stable input needed to accept a level change (range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-005 The block SHALL have port clear, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have port btn_in, input, N_BTN bits: raw asynchronous bouncy push-button levels, 1 = pressed.
REQ-007 The block SHALL have port press, output, N_BTN bits: one-clk pulse per accepted press, per channel, for direct use as timer start/stop.
REQ-008 The block SHALL have port level, output, N_BTN bits: debounced button level per channel.

Function
REQ-009 Each btn_in bit SHALL pass through a 2-flop synchronizer; all further logic SHALL use only the synchronized bit (sync).
REQ-010 One shared prescaler SHALL count 0..CLK_PER_MS-1 and wrap; tick SHALL be high for the one cycle where count == CLK_PER_MS-1.
REQ-011 Each channel SHALL run a 4-state FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND, with a per-channel stable counter of width clog2(DEBOUNCE_MS+1).
REQ-012 RELEASED: sync=1 -> PRESS_PEND with stable counter cleared to 0; otherwise stay.
REQ-013 PRESS_PEND: sync=0 -> RELEASED (bounce rejected, counter cleared); on tick with sync=1, counter +1; when counter reaches DEBOUNCE_MS -> PRESSED.
REQ-014 PRESSED: sync=0 -> RELEASE_PEND with counter cleared; otherwise stay indefinitely; a held button SHALL NOT repeat press.
REQ-015 RELEASE_PEND: sync=1 -> PRESSED (counter cleared); on tick with sync=0, counter +1; at DEBOUNCE_MS -> RELEASED.
REQ-016 Acceptance latency SHALL be between DEBOUNCE_MS-1 and DEBOUNCE_MS full ms after the first stable sync sample, plus 2 synchronizer cycles.
REQ-017 press[i] SHALL be registered, high exactly one cycle: the cycle after channel i's FSM enters PRESSED from PRESS_PEND; the RELEASE_PEND->PRESSED transition SHALL NOT pulse.
REQ-018 level[i] SHALL be registered, 1 in PRESSED and RELEASE_PEND, 0 in RELEASED and PRESS_PEND.
REQ-019 Channels SHALL be fully independent; simultaneous presses on several channels SHALL yield simultaneous pulses.
REQ-020 Stable counter SHALL never exceed DEBOUNCE_MS (no wrap).
REQ-021 A tick coinciding with a sync change SHALL apply the change rule (abort/clear), not the increment.
REQ-022 A button already held when clear deasserts SHALL be debounced normally and SHALL produce one press pulse.

Reset
REQ-023 While clear=1: synchronizer flops, prescaler, stable counters = 0; all FSMs = RELEASED; press = 0; level = 0.
REQ-024 clear asserted mid-debounce or mid-press SHALL abort immediately with no press pulse emitted during or on exit from reset.
REQ-025 First possible tick after clear deasserts SHALL be CLK_PER_MS cycles later.

Structure
REQ-026 A shared package button_pkg SHALL hold the channel state enum and the default values of CLK_PER_MS and DEBOUNCE_MS.
REQ-027 The per-channel FSM, counter and output registers SHALL be one sub-module debounce_chan, instantiated N_BTN times; synchronizer and prescaler may live in debounce_chan (synchronizer) and the top (prescaler).

Verification (bench uses CLK_PER_MS=10, DEBOUNCE_MS=3)
REQ-028 Clean press: btn_in[0] 0->1 held 100 cycles -> exactly one press[0] pulse 22..32 cycles after the edge, level[0]=1 from the next cycle.
REQ-029 Bounce: btn_in[0] toggled every 4 cycles for 60 cycles then held 1 -> no pulse during toggling, exactly one pulse after stable hold.
REQ-030 Release glitch: held press, 5-cycle low glitch -> level[0] stays 1, no second press pulse; a real release of 40 cycles -> level[0]=0.
REQ-031 Simultaneous: btn_in=2'b11 applied on the same cycle -> press=2'b11 on one identical cycle.
REQ-032 Reset mid-debounce: clear pulsed 15 cycles into PRESS_PEND, button kept high -> no pulse in reset, exactly one pulse 22..32 cycles after clear falls; all outputs 0 during clear.
